// File: rtl/pdm_capture_seq.sv
// rtl/pdm_capture_seq.sv - PDM capture sequencer: start/abort the core, wait on bsy, read samples into a local FIFO.
module pdm_capture_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter int          TIMEOUT    = 255
) (
  input  logic               g_hclk_es1,
  input  logic               hreset_n,
  input  logic               cmd_start,
  input  logic [7:0]         cmd_nwords,
  input  logic               cmd_abort,
  output logic [1:0]         pdm_ctrl,
  output logic [31:0]        pdm_addr,
  input  logic [31:0]        pdm_dout,
  input  logic               pdm_bsy,
  input  logic               fifo_rd,
  output logic [31:0]        fifo_rdata,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               irq
);

  localparam int                TW      = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0]  LVL_MAX = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_BSY, S_CAPTURE, S_READ, S_DRAIN, S_ABORT
  } state_t;

  state_t              state;
  logic [7:0]          n_q;
  logic [7:0]          idx_q;
  logic [TW-1:0]       to_cnt;
  logic [31:0]         addr_q;
  logic [1:0]          ctrl_q;
  logic                pend_q;
  logic                done_q;
  logic                err_q;
  logic                irq_q;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    level;

  logic issue;
  logic push;
  logic pop;
  logic flush;

  // The word whose address is on the bus this cycle lands next cycle, so it
  // already owns a FIFO slot when deciding whether another address may go out.
  assign issue = (state == S_READ) && ((level + {{FIFO_AW{1'b0}}, pend_q}) < LVL_MAX);
  assign flush = cmd_abort;
  assign push  = pend_q && !flush;
  assign pop   = fifo_rd && (level != '0);

  always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
    if (!hreset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge g_hclk_es1) begin
    if (push) mem[wr_ptr] <= pdm_dout;
  end

  always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
    if (!hreset_n) begin
      state  <= S_IDLE;
      n_q    <= 8'd0;
      idx_q  <= 8'd0;
      to_cnt <= '0;
      addr_q <= BASE_ADDR;
      ctrl_q <= 2'b00;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_q  <= 1'b0;
      ctrl_q <= 2'b00;
      pend_q <= 1'b0;
      if (cmd_abort && state != S_IDLE) begin
        state  <= S_ABORT;
        ctrl_q <= 2'b10;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start && !cmd_abort) begin
              n_q    <= (cmd_nwords == 8'd0) ? 8'd1 : cmd_nwords;
              done_q <= 1'b0;
              err_q  <= 1'b0;
              ctrl_q <= 2'b01;
              state  <= S_ARM;
            end
          end
          S_ARM: begin
            to_cnt <= '0;
            state  <= S_WAIT_BSY;
          end
          S_WAIT_BSY: begin
            if (pdm_bsy) begin
              state <= S_CAPTURE;
            end else if (to_cnt == TO_LAST) begin
              err_q <= 1'b1;
              irq_q <= 1'b1;
              state <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          S_CAPTURE: begin
            if (!pdm_bsy) begin
              idx_q  <= 8'd0;
              addr_q <= BASE_ADDR;
              state  <= S_READ;
            end
          end
          S_READ: begin
            if (issue) begin
              pend_q <= 1'b1;
              if (idx_q == n_q - 8'd1) begin
                state <= S_DRAIN;
              end else begin
                idx_q  <= idx_q + 8'd1;
                addr_q <= addr_q + 32'd4;
              end
            end
          end
          S_DRAIN: begin
            done_q <= 1'b1;
            irq_q  <= 1'b1;
            state  <= S_IDLE;
          end
          S_ABORT: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign pdm_ctrl    = ctrl_q;
  assign pdm_addr    = addr_q;
  assign fifo_empty  = (level == '0);
  assign fifo_level  = level;
  assign fifo_rdata  = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_pdm_capture_seq.sv
// tb/tb_pdm_capture_seq.sv - directed bench with a word-queue model of the capture sequencer.
module tb_pdm_capture_seq;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        g_hclk_es1 = 1'b0;
  logic        hreset_n   = 1'b0;
  logic        cmd_start  = 1'b0;
  logic [7:0]  cmd_nwords = 8'd0;
  logic        cmd_abort  = 1'b0;
  logic [1:0]  pdm_ctrl;
  logic [31:0] pdm_addr;
  logic [31:0] pdm_dout   = 32'd0;
  logic        pdm_bsy    = 1'b0;
  logic        fifo_rd    = 1'b0;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        irq;

  pdm_capture_seq dut (
    .g_hclk_es1 (g_hclk_es1),
    .hreset_n   (hreset_n),
    .cmd_start  (cmd_start),
    .cmd_nwords (cmd_nwords),
    .cmd_abort  (cmd_abort),
    .pdm_ctrl   (pdm_ctrl),
    .pdm_addr   (pdm_addr),
    .pdm_dout   (pdm_dout),
    .pdm_bsy    (pdm_bsy),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .irq        (irq)
  );

  always #5 g_hclk_es1 = ~g_hclk_es1;

  int checks = 0;
  int errors = 0;
  int dseed  = 0;
  int pop_cnt, ctrl01_cnt, ctrl10_cnt, irq_cnt, busy_cnt;
  bit pop_en = 1'b0;
  logic [31:0] a_smp = BASE;
  logic [31:0] exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] addr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int k, input int s);
    return 32'hA0 + 32'(k) + (32'(s) << 8);
  endfunction

  // Core model: data for the address seen in the previous cycle.
  always @(posedge g_hclk_es1) begin
    #1;
    pdm_dout = 32'hA0 + ((a_smp - BASE) >> 2) + (32'(dseed) << 8);
    fifo_rd  = pop_en && !fifo_empty;
  end

  always @(negedge g_hclk_es1) begin
    a_smp = pdm_addr;
    if (hreset_n) begin
      chk("empty_vs_level", 32'(fifo_empty), 32'(fifo_level == 5'd0));
      chk("level_bound", 32'(fifo_level <= 5'd16), 32'd1);
      chk("ctrl_legal", 32'(pdm_ctrl != 2'b11), 32'd1);
      if (!fifo_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_head: got %h expected no word", fifo_rdata);
        end else begin
          chk("fifo_head", fifo_rdata, exp_q[0]);
        end
        if (fifo_rd) begin
          popped.push_back(fifo_rdata);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
      if (pdm_ctrl == 2'b01) ctrl01_cnt++;
      if (pdm_ctrl == 2'b10) ctrl10_cnt++;
      if (irq) irq_cnt++;
      if (busy) begin
        busy_cnt++;
        if (addr_log.size() == 0 || addr_log[$] != pdm_addr) addr_log.push_back(pdm_addr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge g_hclk_es1);
    #1;
  endtask

  task automatic start_cmd(input int n);
    @(posedge g_hclk_es1);
    #1;
    cmd_start  = 1'b1;
    cmd_nwords = 8'(n);
    @(posedge g_hclk_es1);
    #1;
    cmd_start  = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge g_hclk_es1);
    #1;
    cmd_abort = 1'b1;
    @(posedge g_hclk_es1);
    #1;
    cmd_abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_words(input int n, input int s);
    int m;
    m = (n == 0) ? 1 : n;
    for (int k = 0; k < m; k++) exp_q.push_back(word_of(k, s));
  endtask

  task automatic bsy_pulse(input int pre, input int hi);
    repeat (pre) @(posedge g_hclk_es1);
    #1;
    pdm_bsy = 1'b1;
    repeat (hi) @(posedge g_hclk_es1);
    #1;
    pdm_bsy = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int c = 0;
    while (!done && c < bound) begin
      @(negedge g_hclk_es1);
      c++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_empty(input string name, input int bound);
    int c = 0;
    while (!fifo_empty && c < bound) begin
      @(negedge g_hclk_es1);
      c++;
    end
    chk(name, 32'(fifo_empty), 32'd1);
  endtask

  task automatic wait_level(input string name, input int lvl, input int bound);
    int c = 0;
    while (int'(fifo_level) < lvl && c < bound) begin
      @(negedge g_hclk_es1);
      c++;
    end
    chk(name, 32'(int'(fifo_level) >= lvl), 32'd1);
  endtask

  task automatic clear_counts();
    pop_cnt = 0; ctrl01_cnt = 0; ctrl10_cnt = 0; irq_cnt = 0; busy_cnt = 0;
    popped.delete();
    addr_log.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"},  32'(pdm_ctrl), 32'd0);
    chk({tag, "_addr"},  pdm_addr, BASE);
    chk({tag, "_rdata"}, fifo_rdata, 32'd0);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err_timeout), 32'd0);
    chk({tag, "_irq"},   32'(irq), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_counts();
    repeat (3) @(posedge g_hclk_es1);
    #2;
    check_reset("reset");
    @(posedge g_hclk_es1);
    #1;
    hreset_n = 1'b1;

    // 1: four words, core returns A0+i
    clear_counts();
    dseed = 0;
    start_cmd(4);
    expect_words(4, 0);
    bsy_pulse(2, 8);
    wait_done("t1_done", 100);
    tick(2);
    chk("t1_ctrl01", 32'(ctrl01_cnt), 32'd1);
    chk("t1_irq", 32'(irq_cnt), 32'd1);
    chk("t1_level", 32'(fifo_level), 32'd4);
    chk("t1_naddr", 32'(addr_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < addr_log.size(); k++)
      chk("t1_addr", addr_log[k], BASE + 32'(4 * k));
    chk("t1_addr_hold", pdm_addr, 32'h8000_000C);
    @(negedge g_hclk_es1);
    pop_en = 1'b1;
    wait_empty("t1_drain", 50);
    pop_en = 1'b0;
    chk("t1_pops", 32'(pop_cnt), 32'd4);
    if (popped.size() == 4) begin
      chk("t1_w0", popped[0], 32'hA0);
      chk("t1_w3", popped[3], 32'hA3);
    end

    // 2: forty words, FIFO fills and READ stalls
    clear_counts();
    dseed = 1;
    start_cmd(40);
    expect_words(40, 1);
    bsy_pulse(2, 3);
    wait_level("t2_fill", 16, 200);
    tick(10);
    chk("t2_stall_level", 32'(fifo_level), 32'd16);
    chk("t2_stall_busy", 32'(busy), 32'd1);
    chk("t2_stall_done", 32'(done), 32'd0);
    @(negedge g_hclk_es1);
    pop_en = 1'b1;
    wait_done("t2_done", 300);
    wait_empty("t2_drain", 50);
    pop_en = 1'b0;
    chk("t2_pops", 32'(pop_cnt), 32'd40);
    chk("t2_model_left", 32'(exp_q.size()), 32'd0);
    chk("t2_irq", 32'(irq_cnt), 32'd1);
    if (popped.size() == 40) chk("t2_w39", popped[39], 32'h1C7);

    // 3: bsy never rises
    clear_counts();
    start_cmd(5);
    begin
      int c = 0;
      while (!err_timeout && c < 400) begin
        @(negedge g_hclk_es1);
        c++;
      end
    end
    tick(2);
    chk("t3_err", 32'(err_timeout), 32'd1);
    chk("t3_irq", 32'(irq_cnt), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd256);

    // 4: abort in CAPTURE with three stale words
    clear_counts();
    dseed = 4;
    start_cmd(3);
    expect_words(3, 4);
    chk("t4_err_cleared", 32'(err_timeout), 32'd0);
    bsy_pulse(2, 2);
    wait_done("t4_pre_done", 100);
    tick(2);
    chk("t4_stale", 32'(fifo_level), 32'd3);
    clear_counts();
    dseed = 5;
    start_cmd(4);
    tick(2);
    pdm_bsy = 1'b1;
    tick(3);
    do_abort();
    tick(2);
    pdm_bsy = 1'b0;
    chk("t4_ctrl10", 32'(ctrl10_cnt), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_irq", 32'(irq_cnt), 32'd0);
    chk("t4_done", 32'(done), 32'd0);

    // 5: zero words means one; start while busy is ignored
    clear_counts();
    dseed = 6;
    @(negedge g_hclk_es1);
    pop_en = 1'b1;
    start_cmd(0);
    expect_words(0, 6);
    tick(2);
    pdm_bsy = 1'b1;
    tick(2);
    start_cmd(9);
    tick(1);
    pdm_bsy = 1'b0;
    wait_done("t5_done", 100);
    wait_empty("t5_drain", 50);
    pop_en = 1'b0;
    tick(3);
    chk("t5_pops", 32'(pop_cnt), 32'd1);
    if (popped.size() > 0) chk("t5_w0", popped[0], 32'h6A0);
    chk("t5_ctrl01", 32'(ctrl01_cnt), 32'd1);
    chk("t5_irq", 32'(irq_cnt), 32'd1);
    chk("t5_addr", pdm_addr, BASE);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6: reset mid-READ, then a fresh run
    clear_counts();
    dseed = 7;
    start_cmd(20);
    expect_words(20, 7);
    bsy_pulse(2, 2);
    wait_level("t6_fill", 5, 100);
    @(posedge g_hclk_es1);
    #3;
    hreset_n = 1'b0;
    #1;
    check_reset("t6_rst");
    exp_q.delete();
    pdm_bsy = 1'b0;
    tick(2);
    hreset_n = 1'b1;
    clear_counts();
    dseed = 8;
    @(negedge g_hclk_es1);
    pop_en = 1'b1;
    start_cmd(4);
    expect_words(4, 8);
    bsy_pulse(2, 3);
    wait_done("t6_done", 100);
    wait_empty("t6_drain", 50);
    pop_en = 1'b0;
    tick(2);
    chk("t6_pops", 32'(pop_cnt), 32'd4);
    if (popped.size() == 4) chk("t6_w3", popped[3], 32'h8A3);
    chk("t6_irq", 32'(irq_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
